wb_sram_slave: RTL and testbench
================================

// Module: wb_sram_slave
// PURPOSE
// Wishbone B4 slave (responder) backing single-port word SRAM; the far end of the i_cache / d_cache master ports.
// Serves classic single-beat cycles and linear incrementing bursts (CTI=010) used for cache line fills/write-backs.
// Sits on the system bus as boot/instruction memory; flags out-of-window or misaligned accesses with ERR.
// PARAMETERS
// ADDR_WIDTH   10            word-address bits; memory = 2**ADDR_WIDTH x 32 bit
// BASE_ADDR    32'h0000_0000 byte base; ADR[31:ADDR_WIDTH+2] must equal BASE_ADDR[31:ADDR_WIDTH+2]
// WAIT_STATES  1             extra cycles inserted before the first ACK of every cycle (0..15)
// PORTS
// clk     in   1   clock, all logic on posedge
// rst     in   1   synchronous reset, active-high
// CYC     in   1   bus cycle valid
// STB     in   1   strobe, beat valid
// WE      in   1   1 = write, 0 = read
// ADR     in   32  byte address, word aligned
// DAT_I   in   32  write data
// SEL     in   4   byte lane enables for writes (SEL[0] = DAT_I[7:0])
// CTI_I   in   3   cycle type: 000 classic, 010 incrementing burst, 111 end of burst
// DAT_O   out  32  read data, valid when ACK=1
// ACK     out  1   beat acknowledge
// ERR     out  1   beat error
// RTY     out  1   constant 0
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): state IDLE, ACK=0, ERR=0, DAT_O=0, wait counter=0, burst address=0. SRAM contents untouched.
//   rst during a burst aborts it; no write occurs in that cycle.
// - States: IDLE, WAIT, BURST. ACK/ERR are registered and each is high for at most one beat.
// - Valid request: CYC&STB; word index = ADR[ADDR_WIDTH+1:2]. Error if ADR[1:0]!=0 or upper bits miss BASE_ADDR.
// - IDLE: request seen -> load counter = WAIT_STATES, go WAIT (counter 0 skips straight to response).
// - WAIT: counter decrements each cycle; at 0 respond: error -> ERR=1, no write; else ACK=1 with read data on DAT_O
//   (synchronous SRAM read issued in last WAIT cycle) or write of DAT_I lanes per SEL.
//   First ACK latency = WAIT_STATES+1 cycles after request sampled in IDLE.
// - After a classic ACK or any ERR: ACK/ERR=0 next cycle, state IDLE; back-to-back classic = 1 beat per WAIT_STATES+2 cycles.
// - CYC or STB drop in WAIT: abort to IDLE, no ACK, no write.
// - Write-then-read of same word: read returns new data (write completes at ACK edge).
// CONFIGURATION
// - WB_BURST_EN defined: first beat acked with CTI_I=010 -> BURST; internal address = index+1 (ADR ignored for later beats).
//   BURST: ACK=1 every cycle CYC&STB=1 (zero wait), address +1 per ACKed beat; STB=0 holds ACK low and address;
//   beat with CTI_I=111 is ACKed then IDLE; CYC=0 -> IDLE next cycle, no further ACK.
//   Address stepping past last word (index 2**ADDR_WIDTH-1) -> that beat gets ERR, state IDLE, no write.
//   CTI_I=000 during BURST treated as 111 (acked, then IDLE).
// - WB_BURST_EN undefined: CTI_I ignored; every beat handled as classic with WAIT_STATES per beat; no BURST state.
// TESTING
// - rst=1 2 cycles, then idle bus -> ACK=ERR=RTY=0, DAT_O=0.
// - WAIT_STATES=1: write 0xDEADBEEF @0x10 SEL=1111, then read @0x10 -> ACK 2 cycles after each request, DAT_O=0xDEADBEEF.
// - Write 0x000000AA @0x14 SEL=0001 over prior 0x11223344 -> read returns 0x112233AA.
// - Read @0x0000_1002 (misaligned) and @0x0001_0000 (outside 4KB window) -> ERR=1 one cycle, ACK=0, memory unchanged.
// - WB_BURST_EN: 8-beat read burst @0x20 (CTI 010x7, 111 last) -> first ACK after 2 cycles, then 7 consecutive ACKs, words 0x20..0x3C in order.
// - WB_BURST_EN: burst starting @0xFF8 with STB gap of 2 cycles -> ACK paused during gap; third beat (past 0xFFC) -> ERR, state IDLE.

Source files
------------

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle between a master and the wb_sram_slave responder.
interface wb_sram_slave_if;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_I;
    logic [3:0]  SEL;
    logic [2:0]  CTI_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        ERR;
    logic        RTY;

    modport master (
        output CYC, STB, WE, ADR, DAT_I, SEL, CTI_I,
        input  DAT_O, ACK, ERR, RTY
    );

    modport slave (
        input  CYC, STB, WE, ADR, DAT_I, SEL, CTI_I,
        output DAT_O, ACK, ERR, RTY
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave backed by a single-port 2**ADDR_WIDTH x 32 SRAM.
// Define WB_BURST_EN to serve linear incrementing bursts (CTI 010 ... 111) at one beat per cycle.
module wb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         rst,
    wb_sram_slave_if.slave bus
);
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT
`ifdef WB_BURST_EN
        ,
        BURST
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [ADDR_WIDTH:0] baddr, baddr_nxt;   // extra MSB flags stepping past the last word
    logic                ack_q, ack_nxt;
    logic                err_q, err_nxt;
    logic [31:0]         dat_q;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic                  mem_we, mem_re;
    logic                  req, bad_req;

    assign req     = bus.CYC & bus.STB;
    assign bad_req = (bus.ADR[1:0] != 2'b00) ||
                     (bus.ADR[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        baddr_nxt = baddr;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        mem_idx   = bus.ADR[ADDR_WIDTH+1:2];
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                // The beat just acknowledged is still on the bus; do not take it twice.
                if (req && !ack_q && !err_q) begin
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (bad_req) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ack_nxt   = 1'b1;
                    mem_we    = bus.WE;
                    mem_re    = !bus.WE;
                    state_nxt = IDLE;
`ifdef WB_BURST_EN
                    if (bus.CTI_I == 3'b010) begin
                        state_nxt = BURST;
                        baddr_nxt = {1'b0, mem_idx} + 1'b1;
                    end
`endif
                end
            end
`ifdef WB_BURST_EN
            BURST: begin
                mem_idx = baddr[ADDR_WIDTH-1:0];
                if (!bus.CYC) begin
                    state_nxt = IDLE;
                end else if (bus.STB) begin
                    if (baddr[ADDR_WIDTH]) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ack_nxt   = 1'b1;
                        mem_we    = bus.WE;
                        mem_re    = !bus.WE;
                        baddr_nxt = baddr + 1'b1;
                        if (bus.CTI_I == 3'b111 || bus.CTI_I == 3'b000)
                            state_nxt = IDLE;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the SRAM array has no reset; its contents survive rst, only the write is blocked.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++)
                if (bus.SEL[b]) mem[mem_idx][8*b +: 8] <= bus.DAT_I[8*b +: 8];
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            baddr <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            baddr <= baddr_nxt;
            ack_q <= ack_nxt;
            err_q <= err_nxt;
            if (mem_re) dat_q <= mem[mem_idx];
        end
    end

    assign bus.DAT_O = dat_q;
    assign bus.ACK   = ack_q;
    assign bus.ERR   = err_q;
    assign bus.RTY   = 1'b0;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed self-checking bench for wb_sram_slave (4 KB window at 0, one wait state).
module tb_wb_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    wb_sram_slave_if bus ();

    wb_sram_slave #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.CYC   = 1'b0;
        bus.STB   = 1'b0;
        bus.WE    = 1'b0;
        bus.ADR   = 32'd0;
        bus.DAT_I = 32'd0;
        bus.SEL   = 4'd0;
        bus.CTI_I = 3'b000;
    endtask

    // Drives one beat, waits (bounded) for ACK/ERR, returns what was seen and edges taken.
    task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti,
                           output logic [31:0] rdata, output logic ack, output logic err,
                           output int lat);
        bus.CYC   = 1'b1;
        bus.STB   = 1'b1;
        bus.WE    = we;
        bus.ADR   = adr;
        bus.DAT_I = dat;
        bus.SEL   = sel;
        bus.CTI_I = cti;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.ACK && !bus.ERR && lat < 20);
        rdata = bus.DAT_O;
        ack   = bus.ACK;
        err   = bus.ERR;
    endtask

    task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        logic [31:0] rd;
        logic a, e;
        int lat;
        classic(1'b1, adr, dat, sel, 3'b000, rd, a, e, lat);
        bus_idle();
        check({tag, "_ack"}, 32'(a), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic a, e;
        int lat;
        classic(1'b0, adr, 32'd0, 4'd0, 3'b000, rd, a, e, lat);
        bus_idle();
        check({tag, "_ack"}, 32'(a), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_dat"}, rd, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_err(input string tag, input logic we, input logic [31:0] adr);
        logic [31:0] rd;
        logic a, e;
        int lat;
        classic(we, adr, 32'h5555_5555, 4'hF, 3'b000, rd, a, e, lat);
        bus_idle();
        check({tag, "_err"}, 32'(e), 32'd1);
        check({tag, "_ack"}, 32'(a), 32'd0);
        @(posedge clk); #1;
        check({tag, "_err_drop"}, 32'(bus.ERR), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic a, e;
        int lat;
        int ack_seen;

        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ack", 32'(bus.ACK), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        check("rst_rty", 32'(bus.RTY), 32'd0);
        check("rst_dat", bus.DAT_O, 32'd0);

        do_write("wr10", 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        do_read("rd10", 32'h0000_0010, 32'hDEAD_BEEF);

        do_write("wr14", 32'h0000_0014, 32'h1122_3344, 4'hF);
        do_write("wr14_lane0", 32'h0000_0014, 32'h0000_00AA, 4'b0001);
        do_read("rd14", 32'h0000_0014, 32'h1122_33AA);

        do_err("misalign", 1'b0, 32'h0000_1002);
        do_err("outside", 1'b0, 32'h0001_0000);
        // Aliases word 0x10 if the window check were missing.
        do_err("outside_wr", 1'b1, 32'h0001_0010);
        do_read("rd10_after_err", 32'h0000_0010, 32'hDEAD_BEEF);

        // Write dropped while still waiting: no ACK and no store.
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1;
        bus.ADR = 32'h0000_0010; bus.DAT_I = 32'hCAFE_F00D; bus.SEL = 4'hF;
        @(posedge clk); #1;
        bus_idle();
        ack_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.ACK) ack_seen++;
        end
        check("abort_no_ack", 32'(ack_seen), 32'd0);
        do_read("rd10_after_abort", 32'h0000_0010, 32'hDEAD_BEEF);

`ifdef WB_BURST_EN
        for (int i = 0; i < 8; i++)
            do_write("pre_burst", 32'h20 + 32'(4 * i), 32'hB000_0020 + 32'(4 * i), 4'hF);
        do_write("pre_ff8", 32'h0000_0FF8, 32'h0FF8_0001, 4'hF);
        do_write("pre_ffc", 32'h0000_0FFC, 32'h0FFC_0002, 4'hF);

        // 8-beat read burst: one wait state, then an ACK every cycle.
        classic(1'b0, 32'h0000_0020, 32'd0, 4'd0, 3'b010, rd, a, e, lat);
        check("burst_lat", 32'(lat), 32'd2);
        check("burst_b1", rd, 32'hB000_0020);
        for (int n = 2; n <= 8; n++) begin
            bus.CTI_I = (n == 8) ? 3'b111 : 3'b010;
            @(posedge clk); #1;
            check("burst_ack", 32'(bus.ACK), 32'd1);
            check("burst_dat", bus.DAT_O, 32'hB000_0020 + 32'(4 * (n - 1)));
        end
        bus_idle();
        @(posedge clk); #1;
        check("burst_end_ack", 32'(bus.ACK), 32'd0);

        // Burst at the top of the window with a 2-cycle STB gap; third beat runs off the end.
        classic(1'b0, 32'h0000_0FF8, 32'd0, 4'd0, 3'b010, rd, a, e, lat);
        check("top_lat", 32'(lat), 32'd2);
        check("top_b1", rd, 32'h0FF8_0001);
        bus.STB = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("top_gap_ack", 32'(bus.ACK), 32'd0);
        end
        bus.STB = 1'b1;
        @(posedge clk); #1;
        check("top_b2_ack", 32'(bus.ACK), 32'd1);
        check("top_b2_dat", bus.DAT_O, 32'h0FFC_0002);
        @(posedge clk); #1;
        check("top_b3_err", 32'(bus.ERR), 32'd1);
        check("top_b3_ack", 32'(bus.ACK), 32'd0);
        bus_idle();
        @(posedge clk); #1;
        check("top_err_drop", 32'(bus.ERR), 32'd0);
        do_read("rd_after_burst", 32'h0000_0024, 32'hB000_0024);
`else
        // Without burst support CTI=010 is a plain classic beat: no follow-on ACK.
        classic(1'b0, 32'h0000_0014, 32'd0, 4'd0, 3'b010, rd, a, e, lat);
        check("cti_ignored_ack", 32'(a), 32'd1);
        check("cti_ignored_dat", rd, 32'h1122_33AA);
        ack_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.ACK) ack_seen++;
        end
        check("cti_ignored_no_burst", 32'(ack_seen), 32'd0);
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        do_read("rd14_again", 32'h0000_0014, 32'h1122_33AA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
